ext_bus_master: RTL and testbench

EXT_BUS_MASTER -- requirements
Module: ext_bus_master

---
 rtl/ext_bus_master_pkg.sv | 42 ++++
 rtl/ext_bus_master_if.sv | 65 ++++++
 rtl/ext_bus_master.sv | 111 +++++++++++
 tb/tb_ext_bus_master.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_bus_master_pkg.sv
// ---------------------------------------------------------------------------
// ext_bus_master_pkg
// Shared definitions for the external bus master and its slaves: FSM state
// encoding, header field positions and a header packing helper.
// ---------------------------------------------------------------------------
package ext_bus_master_pkg;

    // log2 of the cache-line size in bytes (64-byte lines).
    localparam int CLSIZE_E = 6;

    // Header word layout: {write, size[1:0], addr[28:0]}.
    localparam int HDR_W        = 32;
    localparam int ADDR_W       = 29;
    localparam int HDR_WRITE_B  = 31;
    localparam int HDR_SIZE_HI  = 30;
    localparam int HDR_SIZE_LO  = 29;
    localparam int HDR_ADDR_HI  = 28;

    // Access size that selects a full cache-line burst.
    localparam logic [1:0] SIZE_LINE = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } bus_state_e;

    function automatic logic [HDR_W-1:0] make_header(
        input logic              write,
        input logic [1:0]        size,
        input logic [ADDR_W-1:0] addr
    );
        logic [HDR_W-1:0] hdr;
        hdr                           = '0;
        hdr[HDR_WRITE_B]              = write;
        hdr[HDR_SIZE_HI:HDR_SIZE_LO]  = size;
        hdr[HDR_ADDR_HI:0]            = addr;
        return hdr;
    endfunction

endpackage

// File: rtl/ext_bus_master_if.sv
// ---------------------------------------------------------------------------
// ext_bus_master_if
// Bundles the request, write-data, read-data and external bus signals of the
// bus master.
//   req_valid/req_write/req_size/req_addr/req_ready : transaction request
//   wdata_valid/wdata/wdata_ready                   : write beats in
//   rdata_valid/rdata/rdata_last/rdata_ready        : read beats out
//   bus_valid/bus_data/bus_ready                    : master-to-slave word
//   bus_rdata/bus_oe                                : slave-driven word
//   busy                                            : master not idle
// Modport master is the bus master itself; modport slave is everything
// around it (requester, write source, read sink and bus slave).
// ---------------------------------------------------------------------------
interface ext_bus_master_if #(
    parameter int WIDTH = 32
) ();

    logic             req_valid;
    logic             req_write;
    logic [1:0]       req_size;
    logic [28:0]      req_addr;
    logic             req_ready;

    logic             wdata_valid;
    logic [WIDTH-1:0] wdata;
    logic             wdata_ready;

    logic             rdata_valid;
    logic [WIDTH-1:0] rdata;
    logic             rdata_last;
    logic             rdata_ready;

    logic             bus_valid;
    logic [WIDTH-1:0] bus_data;
    logic             bus_ready;
    logic [WIDTH-1:0] bus_rdata;
    logic             bus_oe;

    logic             busy;

    modport master (
        input  req_valid, req_write, req_size, req_addr,
        output req_ready,
        input  wdata_valid, wdata,
        output wdata_ready,
        output rdata_valid, rdata, rdata_last,
        input  rdata_ready,
        output bus_valid, bus_data,
        input  bus_ready, bus_rdata, bus_oe,
        output busy
    );

    modport slave (
        output req_valid, req_write, req_size, req_addr,
        input  req_ready,
        output wdata_valid, wdata,
        input  wdata_ready,
        input  rdata_valid, rdata, rdata_last,
        output rdata_ready,
        input  bus_valid, bus_data,
        output bus_ready, bus_rdata, bus_oe,
        input  busy
    );

endinterface

// File: rtl/ext_bus_master.sv
// ---------------------------------------------------------------------------
// ext_bus_master
// Turns single-beat or cache-line-burst requests into a header word followed
// by data beats on a valid/ready external bus.
//   clk : clock, all state on its rising edge
//   rst : synchronous, active-low reset
//   bif : ext_bus_master_if.master (request, write/read data, bus, busy)
// Parameters: WIDTH (data/bus width), BEATS_LOG2 (log2 beats per burst).
// ---------------------------------------------------------------------------
module ext_bus_master
    import ext_bus_master_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int BEATS_LOG2 = CLSIZE_E - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ext_bus_master_if.master      bif
);

    bus_state_e            state, state_nxt;
    logic [BEATS_LOG2-1:0] cnt, cnt_nxt;
    logic                  accept;
    logic                  beat;

    logic                  lat_write;
    logic [1:0]            lat_size;
    logic [ADDR_W-1:0]     lat_addr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: the request latch has no reset; it is only read in HDR, which is
    // reachable solely through an accept that loads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= bif.req_write;
            lat_size  <= bif.req_size;
            lat_addr  <= bif.req_addr;
        end
    end

    // NOTE: every signal written here gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        accept          = 1'b0;
        beat            = 1'b0;
        bif.req_ready   = 1'b0;
        bif.wdata_ready = 1'b0;
        bif.rdata_valid = 1'b0;
        bif.rdata_last  = 1'b0;
        bif.rdata       = bif.bus_rdata;
        bif.bus_valid   = 1'b0;
        bif.bus_data    = '0;
        bif.busy        = (state != IDLE);

        case (state)
            IDLE: begin
                bif.req_ready = 1'b1;
                if (bif.req_valid) begin
                    accept    = 1'b1;
                    // A burst counts up from 0; a single beat starts at the
                    // last-beat value so its first transfer ends it.
                    cnt_nxt   = (bif.req_size == SIZE_LINE) ? '0 : '1;
                    state_nxt = HDR;
                end
            end
            HDR: begin
                bif.bus_valid = 1'b1;
                bif.bus_data  = WIDTH'(make_header(lat_write, lat_size, lat_addr));
                if (bif.bus_ready) begin
                    state_nxt = lat_write ? WDATA : RDATA;
                end
            end
            WDATA: begin
                bif.bus_valid   = bif.wdata_valid;
                bif.bus_data    = bif.wdata;
                bif.wdata_ready = bif.bus_ready;
                beat            = bif.wdata_valid && bif.bus_ready;
            end
            RDATA: begin
                // The master's valid here tells the slave the sink can take
                // a word; the slave's ready plus output enable carries it.
                bif.bus_valid   = bif.rdata_ready;
                bif.rdata_valid = bif.bus_ready && bif.bus_oe;
                bif.rdata_last  = bif.rdata_valid && (&cnt);
                beat            = bif.rdata_ready && bif.bus_ready;
            end
            default: state_nxt = IDLE;
        endcase

        if (beat) begin
            cnt_nxt = cnt + 1'b1;
            if (&cnt) begin
                state_nxt = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ext_bus_master.sv
// ---------------------------------------------------------------------------
// tb_ext_bus_master
// Directed bench for ext_bus_master: expected bus words and read beats are
// queued when a request is issued and popped as the DUT hands them over.
// ---------------------------------------------------------------------------
module tb_ext_bus_master;

    localparam int NBEATS = 16;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ext_bus_master_if #(.WIDTH(32)) bif ();

    ext_bus_master #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    logic [31:0] exp_bus[$];
    rd_exp_t     exp_rd[$];

    int          checks = 0;
    int          errors = 0;
    int          wr_idx;
    int          rd_idx;
    logic [31:0] wbase;
    bit          cur_write;
    bit          hdr_pending;
    bit          accepted;

    function automatic logic [31:0] rd_pattern(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        bif.wdata     = wbase + 32'(wr_idx);
        bif.bus_rdata = rd_pattern(rd_idx);
    endtask

    // One clock: sample/score on the falling edge, then drive after rising.
    task automatic tick();
        logic [31:0] eb;
        rd_exp_t     er;
        @(negedge clk);
        accepted = 1'b0;
        if (bif.req_valid && bif.req_ready) begin
            accepted    = 1'b1;
            hdr_pending = 1'b1;
        end else if (bif.bus_valid && bif.bus_ready && (hdr_pending || cur_write)) begin
            check("bus_queue_nonempty", 64'(exp_bus.size() != 0), 64'd1);
            if (exp_bus.size() != 0) begin
                eb = exp_bus.pop_front();
                check("bus_word", 64'(bif.bus_data), 64'(eb));
            end
            if (hdr_pending) hdr_pending = 1'b0;
            else             wr_idx++;
        end
        if (bif.rdata_valid && bif.rdata_ready) begin
            check("rd_queue_nonempty", 64'(exp_rd.size() != 0), 64'd1);
            if (exp_rd.size() != 0) begin
                er = exp_rd.pop_front();
                check("rdata", 64'(bif.rdata), 64'(er.data));
                check("rdata_last", 64'(bif.rdata_last), 64'(er.last));
            end
            rd_idx++;
        end
        @(posedge clk);
        #1;
        drive_data();
    endtask

    task automatic issue(input bit write, input logic [1:0] size, input logic [28:0] addr,
                         input logic [31:0] base, input logic [31:0] hdr);
        int      nb;
        int      n;
        rd_exp_t er;
        cur_write = write;
        wr_idx    = 0;
        rd_idx    = 0;
        wbase     = base;
        drive_data();
        exp_bus.push_back(hdr);
        nb = (size == 2'd3) ? NBEATS : 1;
        for (int i = 0; i < nb; i++) begin
            if (write) begin
                exp_bus.push_back(base + 32'(i));
            end else begin
                er.data = rd_pattern(i);
                er.last = (i == nb - 1);
                exp_rd.push_back(er);
            end
        end
        bif.req_valid = 1'b1;
        bif.req_write = write;
        bif.req_size  = size;
        bif.req_addr  = addr;
        n = 0;
        do begin
            tick();
            n++;
        end while (!accepted && n < 20);
        check("req_accepted", 64'(accepted), 64'd1);
        bif.req_valid = 1'b0;
    endtask

    // Runs until busy drops; returns cycles spent after acceptance.
    task automatic run_txn(input int stall_at, input int stall_len, input bit stall_rd,
                           input int abort_at, output int n);
        int idx;
        int stalled;
        stalled = 0;
        n       = 0;
        while (bif.busy && n < 200) begin
            idx           = cur_write ? wr_idx : rd_idx;
            bif.bus_ready   = 1'b1;
            bif.rdata_ready = 1'b1;
            if (!hdr_pending && idx == 3) begin
                check("req_ready_while_busy", 64'(bif.req_ready), 64'd0);
            end
            if (!hdr_pending && idx == stall_at && stalled < stall_len) begin
                stalled++;
                if (stall_rd) bif.rdata_ready = 1'b0;
                else          bif.bus_ready   = 1'b0;
                #1;
                if (stall_rd) check("stall_bus_valid", 64'(bif.bus_valid), 64'd0);
                else          check("stall_wdata_ready", 64'(bif.wdata_ready), 64'd0);
            end
            if (!hdr_pending && idx == abort_at) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
                n++;
                break;
            end
            tick();
            n++;
        end
        bif.bus_ready   = 1'b1;
        bif.rdata_ready = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},        64'(bif.busy),        64'd0);
        check({tag, "_bus_valid"},   64'(bif.bus_valid),   64'd0);
        check({tag, "_wdata_ready"}, 64'(bif.wdata_ready), 64'd0);
        check({tag, "_rdata_valid"}, 64'(bif.rdata_valid), 64'd0);
        check({tag, "_rdata_last"},  64'(bif.rdata_last),  64'd0);
        check({tag, "_req_ready"},   64'(bif.req_ready),   64'd1);
    endtask

    initial begin
        int n;
        bif.req_valid   = 1'b0;
        bif.req_write   = 1'b0;
        bif.req_size    = 2'd0;
        bif.req_addr    = '0;
        bif.wdata_valid = 1'b1;
        bif.wdata       = '0;
        bif.rdata_ready = 1'b1;
        bif.bus_ready   = 1'b1;
        bif.bus_rdata   = '0;
        bif.bus_oe      = 1'b1;
        cur_write       = 1'b0;
        hdr_pending     = 1'b0;
        accepted        = 1'b0;
        wr_idx          = 0;
        rd_idx          = 0;
        wbase           = '0;
        rst             = 1'b0;

        repeat (3) tick();
        check_idle("reset");
        rst = 1'b1;

        // Burst write: header, 16 beats 0..15, busy for HDR + 16 cycles.
        issue(1'b1, 2'd3, 29'h140, 32'd0, 32'hE000_0140);
        run_txn(-1, 0, 1'b0, -1, n);
        check("wr_burst_cycles", 64'(n), 64'd17);
        check("wr_burst_bus_left", 64'(exp_bus.size()), 64'd0);
        check_idle("wr_burst_end");

        // Burst read: 16 beats, last only on the final one.
        issue(1'b0, 2'd3, 29'h140, 32'd0, 32'h6000_0140);
        run_txn(-1, 0, 1'b0, -1, n);
        check("rd_burst_cycles", 64'(n), 64'd17);
        check("rd_burst_left", 64'(exp_rd.size()), 64'd0);
        check("rd_burst_hdr_left", 64'(exp_bus.size()), 64'd0);
        check_idle("rd_burst_end");

        // Single write, size 0.
        issue(1'b1, 2'd0, 29'h1000_0000, 32'h41, 32'h9000_0000);
        run_txn(-1, 0, 1'b0, -1, n);
        check("wr_single_cycles", 64'(n), 64'd2);
        check("wr_single_left", 64'(exp_bus.size()), 64'd0);
        check_idle("wr_single_end");

        // Single read, size 1: one beat flagged last.
        issue(1'b0, 2'd1, 29'h24, 32'd0, 32'h2000_0024);
        run_txn(-1, 0, 1'b0, -1, n);
        check("rd_single_cycles", 64'(n), 64'd2);
        check("rd_single_left", 64'(exp_rd.size()), 64'd0);

        // Burst write with the bus stalled 3 cycles at beat 5.
        issue(1'b1, 2'd3, 29'h200, 32'h100, 32'hE000_0200);
        run_txn(5, 3, 1'b0, -1, n);
        check("wr_stall_cycles", 64'(n), 64'd20);
        check("wr_stall_beats", 64'(wr_idx), 64'(NBEATS));
        check("wr_stall_left", 64'(exp_bus.size()), 64'd0);

        // Burst read with the sink stalled 2 cycles at beat 4.
        issue(1'b0, 2'd3, 29'h280, 32'd0, 32'h6000_0280);
        run_txn(4, 2, 1'b1, -1, n);
        check("rd_stall_cycles", 64'(n), 64'd19);
        check("rd_stall_beats", 64'(rd_idx), 64'(NBEATS));
        check("rd_stall_left", 64'(exp_rd.size()), 64'd0);

        // Reset at beat 7 of a read burst abandons it.
        issue(1'b0, 2'd3, 29'h300, 32'd0, 32'h6000_0300);
        run_txn(-1, 0, 1'b0, 7, n);
        check_idle("abort");
        exp_bus.delete();
        exp_rd.delete();
        hdr_pending = 1'b0;
        tick();
        check_idle("abort_hold");

        // A fresh request after the abort runs normally.
        issue(1'b1, 2'd0, 29'h8, 32'h77, 32'h8000_0008);
        run_txn(-1, 0, 1'b0, -1, n);
        check("post_abort_cycles", 64'(n), 64'd2);
        check("post_abort_left", 64'(exp_bus.size()), 64'd0);
        check_idle("post_abort_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
